// File: rtl/clock_pkg.sv
// Shared mode encodings and BCD limits for the lab digital clock timekeeping path.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2,
        MODE_BAD     = 2'd3
    } mode_e;

    localparam int SM_TENS_MAX = 5;   // seconds / minutes tens digit limit
    localparam int HR_TENS_MAX = 2;   // hour tens digit limit
    localparam int HR_WRAP     = 23;  // last legal hour before rolling to 00
    localparam int UNITS_MAX   = 9;   // last legal BCD units digit

    function automatic int bcd_tens(input int value);
        return value / 10;
    endfunction

    function automatic int bcd_units(input int value);
        return value % 10;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after TENS_MAX:UNITS_LAST_AT_MAX.
// carry is high on the cycle whose increment causes that wrap.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int TENS_MAX          = 5,
    parameter int UNITS_LAST_AT_MAX = 9,
    parameter int TENS_W            = 3,
    parameter int RST_TENS          = 0,
    parameter int RST_UNITS         = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [TENS_W-1:0] tens,
    output logic [3:0]        units,
    output logic              carry
);

    logic [TENS_W-1:0] r_tens;
    logic [3:0]        r_units;
    logic              w_at_max;
    logic              w_units_wrap;

    assign w_at_max     = (r_tens == TENS_W'(TENS_MAX)) && (r_units == 4'(UNITS_LAST_AT_MAX));
    assign w_units_wrap = (r_units >= 4'(UNITS_MAX));
    assign carry        = inc & ~clr & w_at_max;

    // NOTE: state registers use non-blocking assignments so every counter
    // samples the same pre-edge values of its neighbours' carries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tens  <= TENS_W'(RST_TENS);
            r_units <= 4'(RST_UNITS);
        end else if (clr) begin
            r_tens  <= '0;
            r_units <= '0;
        end else if (inc) begin
            if (w_at_max) begin
                r_tens  <= '0;
                r_units <= '0;
            end else if (w_units_wrap) begin
                r_tens  <= r_tens + TENS_W'(1);
                r_units <= '0;
            end else begin
                r_units <= r_units + 4'd1;
            end
        end
    end

    assign tens  = r_tens;
    assign units = r_units;

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping controller: 1 Hz edge detect, RUN/SET_HR/SET_MIN mode FSM,
// BCD hour/minute/second counters and registered blink blanking.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int START_HOUR = 0,
    parameter int START_MIN  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sq_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [1:0] hr_t,
    output logic [3:0] hr_u,
    output logic [2:0] min_t,
    output logic [3:0] min_u,
    output logic [2:0] sec_t,
    output logic [3:0] sec_u,
    output logic [1:0] mode,
    output logic       blank_hr,
    output logic       blank_min
);

    mode_e r_mode;
    mode_e w_mode_next;
    logic  r_sq_prev;
    logic  r_blank_hr;
    logic  r_blank_min;

    logic  w_sec_tick;
    logic  w_run;
    logic  w_sec_inc;
    logic  w_sec_clr;
    logic  w_min_inc;
    logic  w_hr_inc;
    logic  w_sec_carry;
    logic  w_min_carry;
    logic  w_hr_carry_unused;

    // sq_prev resets high so a divider output already high at release is not a tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sq_prev <= 1'b1;
        end else begin
            r_sq_prev <= sq_1hz;
        end
    end

    assign w_sec_tick = sq_1hz & ~r_sq_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode <= MODE_RUN;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    // NOTE: the next-state default is assigned before the case so every path
    // drives it and no latch is inferred.
    always_comb begin
        w_mode_next = r_mode;
        case (r_mode)
            MODE_RUN:     if (btn_mode) w_mode_next = MODE_SET_HR;
            MODE_SET_HR:  if (btn_mode) w_mode_next = MODE_SET_MIN;
            MODE_SET_MIN: if (btn_mode) w_mode_next = MODE_RUN;
            default:      w_mode_next = MODE_RUN;
        endcase
    end

    // A mode press in set mode swallows a simultaneous increment; in RUN the tick still lands.
    assign w_run     = (r_mode == MODE_RUN);
    assign w_sec_inc = w_run & w_sec_tick;
    assign w_sec_clr = (r_mode == MODE_SET_MIN) & btn_mode;
    assign w_min_inc = w_run ? w_sec_carry
                             : ((r_mode == MODE_SET_MIN) & btn_inc & ~btn_mode);
    assign w_hr_inc  = w_run ? w_min_carry
                             : ((r_mode == MODE_SET_HR) & btn_inc & ~btn_mode);

    bcd_mod_counter #(
        .TENS_MAX          (SM_TENS_MAX),
        .UNITS_LAST_AT_MAX (UNITS_MAX),
        .TENS_W            (3),
        .RST_TENS          (0),
        .RST_UNITS         (0)
    ) u_sec (
        .clk   (clk),
        .reset (reset),
        .inc   (w_sec_inc),
        .clr   (w_sec_clr),
        .tens  (sec_t),
        .units (sec_u),
        .carry (w_sec_carry)
    );

    bcd_mod_counter #(
        .TENS_MAX          (SM_TENS_MAX),
        .UNITS_LAST_AT_MAX (UNITS_MAX),
        .TENS_W            (3),
        .RST_TENS          (bcd_tens(START_MIN)),
        .RST_UNITS         (bcd_units(START_MIN))
    ) u_min (
        .clk   (clk),
        .reset (reset),
        .inc   (w_min_inc),
        .clr   (1'b0),
        .tens  (min_t),
        .units (min_u),
        .carry (w_min_carry)
    );

    bcd_mod_counter #(
        .TENS_MAX          (HR_TENS_MAX),
        .UNITS_LAST_AT_MAX (bcd_units(HR_WRAP)),
        .TENS_W            (2),
        .RST_TENS          (bcd_tens(START_HOUR)),
        .RST_UNITS         (bcd_units(START_HOUR))
    ) u_hr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_hr_inc),
        .clr   (1'b0),
        .tens  (hr_t),
        .units (hr_u),
        .carry (w_hr_carry_unused)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blank_hr  <= 1'b0;
            r_blank_min <= 1'b0;
        end else begin
            r_blank_hr  <= (r_mode == MODE_SET_HR)  & ~sq_1hz;
            r_blank_min <= (r_mode == MODE_SET_MIN) & ~sq_1hz;
        end
    end

    assign mode      = r_mode;
    assign blank_hr  = r_blank_hr;
    assign blank_min = r_blank_min;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl: one instance starting at 00:00, one preloaded to 23:59.
module tb_clock_time_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sq = 1'b0;
    logic btn_mode = 1'b0;
    logic btn_inc = 1'b0;

    logic [1:0] a_hr_t, b_hr_t;
    logic [3:0] a_hr_u, b_hr_u;
    logic [2:0] a_min_t, b_min_t;
    logic [3:0] a_min_u, b_min_u;
    logic [2:0] a_sec_t, b_sec_t;
    logic [3:0] a_sec_u, b_sec_u;
    logic [1:0] a_mode, b_mode;
    logic a_blank_hr, a_blank_min, b_blank_hr, b_blank_min;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_time_ctrl #(.START_HOUR(0), .START_MIN(0)) dut (
        .clk(clk), .reset(reset), .sq_1hz(sq), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hr_t(a_hr_t), .hr_u(a_hr_u), .min_t(a_min_t), .min_u(a_min_u),
        .sec_t(a_sec_t), .sec_u(a_sec_u), .mode(a_mode),
        .blank_hr(a_blank_hr), .blank_min(a_blank_min)
    );

    clock_time_ctrl #(.START_HOUR(23), .START_MIN(59)) dut_pre (
        .clk(clk), .reset(reset), .sq_1hz(sq), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hr_t(b_hr_t), .hr_u(b_hr_u), .min_t(b_min_t), .min_u(b_min_u),
        .sec_t(b_sec_t), .sec_u(b_sec_u), .mode(b_mode),
        .blank_hr(b_blank_hr), .blank_min(b_blank_min)
    );

    wire [19:0] now_a = {a_hr_t, a_hr_u, a_min_t, a_min_u, a_sec_t, a_sec_u};
    wire [19:0] now_b = {b_hr_t, b_hr_u, b_min_t, b_min_u, b_sec_t, b_sec_u};

    function automatic logic [19:0] bcd_time(input int h, input int m, input int s);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        sq = 1'b0;
        step(1);
        sq = 1'b1;
        step(1);
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1;
        step(1);
        btn_mode = 1'b0;
    endtask

    task automatic pulse_inc();
        btn_inc = 1'b1;
        step(1);
        btn_inc = 1'b0;
        step(1);
    endtask

    task automatic apply_reset();
        sq = 1'b0;
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        sq = 1'b0;
        reset = 1'b0;
        step(2);
        checks++;
        if (now_a !== bcd_time(0, 0, 0)) begin
            errors++;
            $display("FAIL reset_time got %h exp %h", now_a, bcd_time(0, 0, 0));
        end
        checks++;
        if ({a_mode, a_blank_hr, a_blank_min} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mode_blank got %b exp 0000", {a_mode, a_blank_hr, a_blank_min});
        end
        checks++;
        if (now_b !== bcd_time(23, 59, 0)) begin
            errors++;
            $display("FAIL reset_preload got %h exp %h", now_b, bcd_time(23, 59, 0));
        end
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_run();
        for (int i = 1; i <= 60; i++) begin
            tick();
            checks++;
            if (now_a !== bcd_time(0, i / 60, i % 60)) begin
                errors++;
                $display("FAIL run_tick%0d got %h exp %h", i, now_a, bcd_time(0, i / 60, i % 60));
            end
        end
        step(3);
        checks++;
        if (now_a !== bcd_time(0, 1, 0) || a_mode !== 2'd0) begin
            errors++;
            $display("FAIL run_hold_high got %h mode %0d exp %h mode 0", now_a, a_mode, bcd_time(0, 1, 0));
        end
        checks++;
        if (now_b !== bcd_time(0, 0, 0)) begin
            errors++;
            $display("FAIL run_preload_wrap got %h exp %h", now_b, bcd_time(0, 0, 0));
        end
    endtask

    task automatic test_preload_wrap();
        apply_reset();
        for (int i = 0; i < 59; i++) tick();
        checks++;
        if (now_b !== bcd_time(23, 59, 59)) begin
            errors++;
            $display("FAIL wrap_235959 got %h exp %h", now_b, bcd_time(23, 59, 59));
        end
        sq = 1'b0;
        step(1);
        checks++;
        if (now_b !== bcd_time(23, 59, 59)) begin
            errors++;
            $display("FAIL wrap_before_edge got %h exp %h", now_b, bcd_time(23, 59, 59));
        end
        sq = 1'b1;
        step(1);
        checks++;
        if (now_b !== bcd_time(0, 0, 0)) begin
            errors++;
            $display("FAIL wrap_midnight got %h exp %h", now_b, bcd_time(0, 0, 0));
        end
    endtask

    task automatic test_set();
        apply_reset();
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (now_a !== bcd_time(0, 0, 7)) begin
            errors++;
            $display("FAIL set_pre_time got %h exp %h", now_a, bcd_time(0, 0, 7));
        end
        pulse_mode();
        checks++;
        if (a_mode !== 2'd1) begin
            errors++;
            $display("FAIL set_enter_hr got %0d exp 1", a_mode);
        end
        for (int i = 0; i < 25; i++) begin
            sq = ~sq;
            pulse_inc();
        end
        checks++;
        if (now_a !== bcd_time(1, 0, 7) || a_mode !== 2'd1) begin
            errors++;
            $display("FAIL set_hr_25 got %h mode %0d exp %h mode 1", now_a, a_mode, bcd_time(1, 0, 7));
        end
        pulse_mode();
        checks++;
        if (a_mode !== 2'd2) begin
            errors++;
            $display("FAIL set_enter_min got %0d exp 2", a_mode);
        end
        for (int i = 0; i < 61; i++) pulse_inc();
        checks++;
        if (now_a !== bcd_time(1, 1, 7)) begin
            errors++;
            $display("FAIL set_min_61 got %h exp %h", now_a, bcd_time(1, 1, 7));
        end
        pulse_mode();
        checks++;
        if (now_a !== bcd_time(1, 1, 0) || a_mode !== 2'd0) begin
            errors++;
            $display("FAIL set_exit_clear got %h mode %0d exp %h mode 0", now_a, a_mode, bcd_time(1, 1, 0));
        end
    endtask

    task automatic test_same_cycle_and_blank();
        apply_reset();
        pulse_mode();
        sq = 1'b0;
        step(2);
        checks++;
        if ({a_blank_hr, a_blank_min} !== 2'b10) begin
            errors++;
            $display("FAIL blank_hr_low got %b exp 10", {a_blank_hr, a_blank_min});
        end
        sq = 1'b1;
        step(2);
        checks++;
        if ({a_blank_hr, a_blank_min} !== 2'b00) begin
            errors++;
            $display("FAIL blank_hr_high got %b exp 00", {a_blank_hr, a_blank_min});
        end
        for (int i = 0; i < 3; i++) pulse_inc();
        btn_mode = 1'b1;
        btn_inc = 1'b1;
        step(1);
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        checks++;
        if (now_a !== bcd_time(3, 0, 0) || a_mode !== 2'd2) begin
            errors++;
            $display("FAIL mode_beats_inc got %h mode %0d exp %h mode 2", now_a, a_mode, bcd_time(3, 0, 0));
        end
        sq = 1'b0;
        step(2);
        checks++;
        if ({a_blank_hr, a_blank_min} !== 2'b01) begin
            errors++;
            $display("FAIL blank_min_low got %b exp 01", {a_blank_hr, a_blank_min});
        end
        pulse_mode();
        step(1);
        checks++;
        if ({a_mode, a_blank_hr, a_blank_min} !== 4'b0000) begin
            errors++;
            $display("FAIL blank_run got %b exp 0000", {a_mode, a_blank_hr, a_blank_min});
        end
        sq = 1'b1;
        btn_mode = 1'b1;
        step(1);
        btn_mode = 1'b0;
        checks++;
        if (now_a !== bcd_time(3, 0, 1) || a_mode !== 2'd1) begin
            errors++;
            $display("FAIL tick_with_mode got %h mode %0d exp %h mode 1", now_a, a_mode, bcd_time(3, 0, 1));
        end
    endtask

    task automatic test_reset_sq_high();
        sq = 1'b1;
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(3);
        checks++;
        if (now_a !== bcd_time(0, 0, 0)) begin
            errors++;
            $display("FAIL release_high_no_tick got %h exp %h", now_a, bcd_time(0, 0, 0));
        end
        sq = 1'b0;
        step(1);
        checks++;
        if (now_a !== bcd_time(0, 0, 0)) begin
            errors++;
            $display("FAIL release_low got %h exp %h", now_a, bcd_time(0, 0, 0));
        end
        sq = 1'b1;
        step(1);
        checks++;
        if (now_a !== bcd_time(0, 0, 1)) begin
            errors++;
            $display("FAIL release_first_tick got %h exp %h", now_a, bcd_time(0, 0, 1));
        end
    endtask

    task automatic test_reset_mid_set();
        apply_reset();
        pulse_mode();
        for (int i = 0; i < 12; i++) pulse_inc();
        pulse_mode();
        for (int i = 0; i < 34; i++) pulse_inc();
        pulse_mode();
        for (int i = 0; i < 56; i++) tick();
        pulse_mode();
        pulse_mode();
        sq = 1'b0;
        step(2);
        checks++;
        if (now_a !== bcd_time(12, 34, 56) || a_mode !== 2'd2 || a_blank_min !== 1'b1) begin
            errors++;
            $display("FAIL mid_set_setup got %h mode %0d blank_min %b exp %h mode 2 blank_min 1",
                     now_a, a_mode, a_blank_min, bcd_time(12, 34, 56));
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (now_a !== bcd_time(0, 0, 0) || {a_mode, a_blank_hr, a_blank_min} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_set_reset got %h flags %b exp %h flags 0000",
                     now_a, {a_mode, a_blank_hr, a_blank_min}, bcd_time(0, 0, 0));
        end
        step(2);
        checks++;
        if (now_a !== bcd_time(0, 0, 0) || a_mode !== 2'd0 || now_b !== bcd_time(23, 59, 0)) begin
            errors++;
            $display("FAIL mid_set_reset_hold got %h mode %0d pre %h exp %h mode 0 pre %h",
                     now_a, a_mode, now_b, bcd_time(0, 0, 0), bcd_time(23, 59, 0));
        end
        reset = 1'b1;
        step(1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run();
        test_preload_wrap();
        test_set();
        test_same_cycle_and_blank();
        test_reset_sq_high();
        test_reset_mid_set();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Timekeeping controller for the lab digital clock. It consumes the 1 Hz square wave from the clock divider and keeps hours, minutes and seconds as BCD digits. A three-state mode FSM lets the user set hours and minutes with two single-cycle button pulses. Outputs drive the seven-segment decoder stage, including per-field blanking for the blink effect in set mode.

## Interface
- START_HOUR, 0, hour loaded on reset (0..23, binary).
- START_MIN, 0, minute loaded on reset (0..59, binary).
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- sq_1hz  in  1  1 Hz square wave from the divider, synchronous to clk.
- btn_mode  in  1  one-cycle pulse (debounced upstream); advances mode.
- btn_inc  in  1  one-cycle pulse; increments the field being set.
- hr_t  out  2  hour tens, BCD 0..2.
- hr_u  out  4  hour units, BCD 0..9.
- min_t  out  3  minute tens, BCD 0..5.
- min_u  out  4  minute units, BCD.
- sec_t  out  3  second tens, BCD 0..5.
- sec_u  out  4  second units, BCD.
- mode  out  2  0 = RUN, 1 = SET_HR, 2 = SET_MIN.
- blank_hr  out  1  1 = hour digits blanked.
- blank_min  out  1  1 = minute digits blanked.

## Operation
- Edge detect: sq_prev is registered from sq_1hz. sec_tick = sq_1hz & ~sq_prev.
- sq_prev resets to 1, so no tick is generated if sq_1hz is already high when reset releases.
- FSM transitions, all taken on btn_mode:
  - RUN -> SET_HR
  - SET_HR -> SET_MIN
  - SET_MIN -> RUN
  - Encoding 3 is illegal and returns to RUN on the next clock.
- RUN: each sec_tick advances the time by 1 s.
  - sec_u wraps 9->0 and carries into sec_t.
  - sec_t wraps 5->0 and carries into minutes.
  - Minutes roll 59->00 with carry into hours.
  - Hours roll 23->00, so 23:59:59 goes to 00:00:00 on one tick.
  - btn_inc is ignored in RUN.
- SET_HR: time is frozen and sec_tick is ignored. btn_inc increments hours mod 24 (23->00). Minutes and seconds are unaffected.
- SET_MIN: btn_inc increments minutes mod 60 (59->00). There is no carry into hours.
- Leaving SET_MIN for RUN clears sec_t and sec_u to 0 on the same edge.
- btn_mode and btn_inc in the same cycle: the mode change wins and the increment is dropped.
- btn_mode and sec_tick in the same cycle while in RUN: the tick is applied and the mode moves to SET_HR.
- Blanking:
  - blank_hr = (mode == SET_HR) & ~sq_1hz.
  - blank_min = (mode == SET_MIN) & ~sq_1hz.
  - Both are registered outputs.
- Digit outputs are always legal BCD. No value outside the ranges listed in the interface is ever produced.

## Timing
- Reset values:
  - Time = START_HOUR:START_MIN:00, in BCD.
  - mode = 0, blank_hr = 0, blank_min = 0, sq_prev = 1.
- Tick latency: if sq_1hz is sampled 1 in cycle N with sq_prev = 0, the digits update at the end of cycle N and are visible in cycle N+1.
- Button latency: a pulse sampled in cycle N updates mode or digits, visible in cycle N+1. One increment per pulse.
- Blank latency: one cycle after sq_1hz or mode changes.
- Reset asserted mid-operation (any mode, any time): all outputs return to reset values immediately. The first tick after release needs a fresh rising edge of sq_1hz.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package clock_pkg:
  - Mode encodings MODE_RUN, MODE_SET_HR, MODE_SET_MIN.
  - BCD limit constants for the seconds/minutes tens digit (5), hour tens digit (2), hour wrap point (23) and units digit (9).
- Sub-module bcd_mod_counter:
  - Parameters TENS_MAX and UNITS_LAST_AT_MAX.
  - Inputs inc and clr; outputs tens, units and carry.
  - Instantiated for seconds (5/9), minutes (5/9) and hours (2/3).
  - Hours use a special wrap: 23 -> 00.
- The top holds the FSM, the edge detect, the blank registers and the increment muxing.

## Test plan
- Reset with START_HOUR=0, START_MIN=0. Run 60 sq_1hz periods (shortened in the bench) -> time reads 00:01:00 and mode=0. Exactly one digit update per rising edge.
- Preload via parameters to 23:59, then 59 ticks and one more -> time reads 23:59:59 then 00:00:00, all digits updating on the same cycle.
- Pulse btn_mode once, then btn_inc 25 times -> mode=1, hour 00->01, with sec_tick ignored. Then pulse btn_mode -> mode=2; btn_inc 61 times -> minutes 01. Then btn_mode -> mode=0 and seconds read 00.
- In SET_HR, drive btn_mode and btn_inc in the same cycle -> mode=2 and the hour is unchanged. In SET_HR with sq_1hz low -> blank_hr=1 and blank_min=0 one cycle later.
- Hold sq_1hz high while deasserting reset -> no tick. Then low then high -> seconds 00->01 one cycle after the rise is sampled.
- Assert reset mid-SET_MIN at 12:34:56 -> outputs return to 00:00:00 with mode=0 while reset is low.
